frame_controller: RTL and testbench
===================================

FRAME_CONTROLLER -- requirements
Module: frame_controller

Interface
REQ-001 SHALL have parameter FRAME_PERIOD, default 2_000_000: minimum gpu_clk cycles between buffer swaps.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 64: consecutive idle cycles that define a drained pipeline.
REQ-003 SHALL have ports:
- clk_in  input  1  gpu clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- framebuffer_ready_in  input  1  framebuffer accepts pixels.
- fetch_done_in  input  1  one-cycle pulse: vertex_fetch emitted its last vertex.
- pipeline_busy_in  input  1  OR of valid flags in shader, fifo, rasterizer and fragment stages.
- pixel_valid_in  input  1  pixel written to the framebuffer this cycle.
- fetch_rst_out  output  1  holds vertex_fetch in reset.
- clear_out  output  1  one-cycle framebuffer clear pulse.
- switch_out  output  1  one-cycle framebuffer swap pulse.
- frame_count_out  output  16  completed frames.
- pixel_count_out  output  16  pixels written in the last completed frame.
- overrun_out  output  1  sticky; a frame exceeded FRAME_PERIOD.

Function
REQ-004 SHALL implement states WAIT_READY, RENDER, DRAIN, WAIT_TIMER and SWAP.
REQ-005 WAIT_READY: fetch_rst_out=1; when framebuffer_ready_in=1, SHALL clear the pixel accumulator, drive fetch_rst_out=0 from the next cycle, and enter RENDER.
REQ-006 RENDER: on fetch_done_in=1, SHALL enter DRAIN.
REQ-007 DRAIN: an idle counter SHALL increment on each cycle with pipeline_busy_in=0 and reset to 0 on any busy cycle; when it reaches DRAIN_CYCLES, SHALL set fetch_rst_out=1 and enter WAIT_TIMER.
REQ-008 WAIT_TIMER: when period timer >= FRAME_PERIOD-1, SHALL enter SWAP; otherwise SHALL hold.
REQ-009 SWAP (exactly one cycle): clear_out=1, switch_out=1, pixel_count_out <= accumulator, frame_count_out += 1 (wraps at 0xFFFF->0), period timer <= 0; next state WAIT_READY.
REQ-010 clear_out and switch_out SHALL be registered and high only in the cycle after the SWAP decision, never for 2 consecutive cycles.
REQ-011 Period timer SHALL increment every cycle outside SWAP and saturate at FRAME_PERIOD-1.
REQ-012 If the timer saturates while in WAIT_READY, RENDER or DRAIN, SHALL set overrun_out=1 (sticky until reset); WAIT_TIMER then exits on its first cycle.
REQ-013 Pixel accumulator SHALL count pixel_valid_in only in RENDER and DRAIN and saturate at 0xFFFF; pixel_valid_in in other states SHALL be ignored.
REQ-014 fetch_done_in outside RENDER SHALL be ignored; fetch_done_in and pixel_valid_in in the same cycle SHALL both take effect.
REQ-015 If framebuffer_ready_in drops during RENDER or DRAIN, SHALL continue the current state; readiness is sampled only in WAIT_READY.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 On rst_in=1 at a clock edge, SHALL enter WAIT_READY with fetch_rst_out=1, clear_out=0, switch_out=0, frame_count_out=0, pixel_count_out=0, overrun_out=0, and timer, idle counter and accumulator = 0.
REQ-018 Reset asserted mid-frame, including in SWAP, SHALL take priority over all transitions, and no clear/switch pulse SHALL appear in the cycle after reset.

Structure
REQ-019 The state enum frame_ctrl_state_t and the default FRAME_PERIOD and DRAIN_CYCLES constants SHALL live in the shared gpu_pkg package.
REQ-020 SHALL be a single module with no sub-modules; counters are inline.
REQ-021 Timer width SHALL be $clog2(FRAME_PERIOD) and idle counter width SHALL be $clog2(DRAIN_CYCLES+1).

Verification (FRAME_PERIOD=100, DRAIN_CYCLES=4)
REQ-022 Normal frame: ready at cycle 2, 10 pixel pulses, fetch_done at 30, busy low from 31 -> fetch_rst_out rises at 35; single clear/switch pulse at timer 99; pixel_count_out=10; frame_count_out=1.
REQ-023 Drain restart: busy low 3 cycles, high 1 cycle, then low -> fetch_rst_out rises only after 4 consecutive idle cycles.
REQ-024 Overrun: fetch_done at cycle 150 -> overrun_out=1 at timer saturation; SWAP occurs 1 cycle after WAIT_TIMER is entered; overrun_out stays 1 over the next frame.
REQ-025 Saturation and wrap: 70000 pixel pulses -> pixel_count_out=0xFFFF; preload 0xFFFF frames, then one swap -> frame_count_out=0.
REQ-026 Reset mid-RENDER with 5 pixels counted -> all outputs at reset values next cycle; the next frame reports only its own pixels.
REQ-027 Stray inputs: fetch_done_in in WAIT_READY and pixel_valid_in in WAIT_TIMER -> no state change and no count change.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared GPU types and default constants for the frame controller
//
// Purpose: holds the frame controller state enum and the default frame period
// and drain length so other GPU blocks can refer to the same values.
// Ports: none (package).

package gpu_pkg;

    // Minimum gpu_clk cycles between buffer swaps.
    localparam int unsigned DEFAULT_FRAME_PERIOD = 2_000_000;

    // Consecutive idle cycles that define a drained pipeline.
    localparam int unsigned DEFAULT_DRAIN_CYCLES = 64;

    // Ceiling for the 16-bit frame and pixel counters.
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        WAIT_READY = 3'd0,
        RENDER     = 3'd1,
        DRAIN      = 3'd2,
        WAIT_TIMER = 3'd3,
        SWAP       = 3'd4
    } frame_ctrl_state_t;

endpackage

// File: rtl/frame_controller.sv
// rtl/frame_controller.sv - per-frame sequencing of vertex fetch, drain and buffer swap
//
// Purpose: releases vertex_fetch once the framebuffer is ready, waits for the
// last vertex and a drained pipeline, then swaps buffers no faster than one
// swap per FRAME_PERIOD cycles. Counts frames and pixels, flags overruns.
//
// Ports:
//   clk_in               gpu clock
//   rst_in               synchronous active-high reset
//   framebuffer_ready_in framebuffer accepts pixels (sampled only in WAIT_READY)
//   fetch_done_in        pulse: last vertex emitted (honoured only in RENDER)
//   pipeline_busy_in     any pipeline stage holds valid data
//   pixel_valid_in       pixel written this cycle (counted in RENDER/DRAIN)
//   fetch_rst_out        holds vertex_fetch in reset
//   clear_out            one-cycle framebuffer clear pulse
//   switch_out           one-cycle framebuffer swap pulse
//   frame_count_out      completed frames (wraps)
//   pixel_count_out      pixels written in the last completed frame (saturating)
//   overrun_out          sticky: a frame took longer than FRAME_PERIOD

module frame_controller
    import gpu_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD = DEFAULT_FRAME_PERIOD,
    parameter int unsigned DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        framebuffer_ready_in,
    input  logic        fetch_done_in,
    input  logic        pipeline_busy_in,
    input  logic        pixel_valid_in,
    output logic        fetch_rst_out,
    output logic        clear_out,
    output logic        switch_out,
    output logic [15:0] frame_count_out,
    output logic [15:0] pixel_count_out,
    output logic        overrun_out
);

    localparam int unsigned TIMER_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int unsigned IDLE_W  = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(FRAME_PERIOD - 1);
    localparam logic [IDLE_W-1:0]  IDLE_DONE = IDLE_W'(DRAIN_CYCLES);

    frame_ctrl_state_t  state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic [15:0]        pixel_count_q, pixel_count_d;
    logic               overrun_q, overrun_d;
    logic               fetch_rst_q, fetch_rst_d;
    logic               swap_pulse_q, swap_pulse_d;

    logic timer_sat;
    logic acc_inc;

    assign timer_sat = (timer_q >= TIMER_MAX);
    assign acc_inc   = pixel_valid_in && (acc_q != COUNT_MAX);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_sat ? timer_q : timer_q + 1'b1;
        idle_d        = '0;
        acc_d         = acc_q;
        frame_count_d = frame_count_q;
        pixel_count_d = pixel_count_q;
        overrun_d     = overrun_q;

        unique case (state_q)
            WAIT_READY: begin
                if (timer_sat) begin
                    overrun_d = 1'b1;
                end
                if (framebuffer_ready_in) begin
                    acc_d   = '0;
                    state_d = RENDER;
                end
            end

            RENDER: begin
                if (timer_sat) begin
                    overrun_d = 1'b1;
                end
                if (acc_inc) begin
                    acc_d = acc_q + 16'd1;
                end
                // A pixel arriving with the last vertex is still counted above.
                if (fetch_done_in) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if (timer_sat) begin
                    overrun_d = 1'b1;
                end
                if (acc_inc) begin
                    acc_d = acc_q + 16'd1;
                end
                // Any busy cycle restarts the idle run; the exit is decided on
                // the cycle that completes the run so fetch reset lands on the
                // next cycle.
                if (pipeline_busy_in) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_d == IDLE_DONE) begin
                        state_d = WAIT_TIMER;
                    end
                end
            end

            WAIT_TIMER: begin
                if (timer_sat) begin
                    state_d = SWAP;
                end
            end

            SWAP: begin
                timer_d       = '0;
                pixel_count_d = acc_q;
                frame_count_d = frame_count_q + 16'd1;
                state_d       = WAIT_READY;
            end

            default: begin
                state_d = WAIT_READY;
            end
        endcase

        // Registered outputs follow the state being entered.
        fetch_rst_d  = !((state_d == RENDER) || (state_d == DRAIN));
        swap_pulse_d = (state_d == SWAP);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= WAIT_READY;
            timer_q       <= '0;
            idle_q        <= '0;
            acc_q         <= '0;
            frame_count_q <= '0;
            pixel_count_q <= '0;
            overrun_q     <= 1'b0;
            fetch_rst_q   <= 1'b1;
            swap_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            idle_q        <= idle_d;
            acc_q         <= acc_d;
            frame_count_q <= frame_count_d;
            pixel_count_q <= pixel_count_d;
            overrun_q     <= overrun_d;
            fetch_rst_q   <= fetch_rst_d;
            swap_pulse_q  <= swap_pulse_d;
        end
    end

    assign fetch_rst_out   = fetch_rst_q;
    assign clear_out       = swap_pulse_q;
    assign switch_out      = swap_pulse_q;
    assign frame_count_out = frame_count_q;
    assign pixel_count_out = pixel_count_q;
    assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_frame_controller.sv
// tb/tb_frame_controller.sv - directed self-checking bench for frame_controller

module tb_frame_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        framebuffer_ready_in;
    logic        fetch_done_in;
    logic        pipeline_busy_in;
    logic        pixel_valid_in;
    logic        fetch_rst_out;
    logic        clear_out;
    logic        switch_out;
    logic [15:0] frame_count_out;
    logic [15:0] pixel_count_out;
    logic        overrun_out;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    frame_controller #(
        .FRAME_PERIOD(100),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .framebuffer_ready_in(framebuffer_ready_in),
        .fetch_done_in       (fetch_done_in),
        .pipeline_busy_in    (pipeline_busy_in),
        .pixel_valid_in      (pixel_valid_in),
        .fetch_rst_out       (fetch_rst_out),
        .clear_out           (clear_out),
        .switch_out          (switch_out),
        .frame_count_out     (frame_count_out),
        .pixel_count_out     (pixel_count_out),
        .overrun_out         (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int k);
        while (cyc < k) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fetch_rst"}, 32'(fetch_rst_out), 32'd1);
        check({tag, "_clear"},     32'(clear_out),     32'd0);
        check({tag, "_switch"},    32'(switch_out),    32'd0);
        check({tag, "_frames"},    32'(frame_count_out), 32'd0);
        check({tag, "_pixels"},    32'(pixel_count_out), 32'd0);
        check({tag, "_overrun"},   32'(overrun_out),   32'd0);
    endtask

    initial begin
        rst_in               = 1'b1;
        framebuffer_ready_in = 1'b0;
        fetch_done_in        = 1'b0;
        pipeline_busy_in     = 1'b0;
        pixel_valid_in       = 1'b0;
        tick();
        tick();
        check_reset_values("por");
        rst_in = 1'b0;
        cyc    = 0;

        // Frame 1: normal frame, pixels 21..30, last pixel coincides with fetch_done.
        pipeline_busy_in = 1'b1;
        run_until(2);
        check("f1_wait_fetch_rst", 32'(fetch_rst_out), 32'd1);
        framebuffer_ready_in = 1'b1;
        tick();
        framebuffer_ready_in = 1'b0;
        check("f1_render_fetch_rst", 32'(fetch_rst_out), 32'd0);
        run_until(21);
        pixel_valid_in = 1'b1;
        run_until(30);
        fetch_done_in = 1'b1;
        tick();
        pixel_valid_in   = 1'b0;
        fetch_done_in    = 1'b0;
        pipeline_busy_in = 1'b0;
        run_until(34);
        check("f1_drain_34", 32'(fetch_rst_out), 32'd0);
        tick();
        check("f1_drain_done_35", 32'(fetch_rst_out), 32'd1);
        run_until(99);
        check("f1_no_early_clear", 32'(clear_out), 32'd0);
        tick();
        check("f1_clear", 32'(clear_out), 32'd1);
        check("f1_switch", 32'(switch_out), 32'd1);
        tick();
        check("f1_clear_single", 32'(clear_out), 32'd0);
        check("f1_pixels", 32'(pixel_count_out), 32'd10);
        check("f1_frames", 32'(frame_count_out), 32'd1);
        check("f1_overrun", 32'(overrun_out), 32'd0);

        // Frame 2: reset after 5 pixels in RENDER.
        cyc = 0;
        pipeline_busy_in = 1'b1;
        run_until(2);
        framebuffer_ready_in = 1'b1;
        tick();
        framebuffer_ready_in = 1'b0;
        pixel_valid_in = 1'b1;
        run_until(8);
        pixel_valid_in = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("f2_rst_frames", 32'(frame_count_out), 32'd0);
        check("f2_rst_pixels", 32'(pixel_count_out), 32'd0);
        check("f2_rst_fetch_rst", 32'(fetch_rst_out), 32'd1);

        // Frame 3: stray fetch_done in WAIT_READY, drain restart, stray pixels in WAIT_TIMER.
        cyc = 0;
        run_until(1);
        fetch_done_in = 1'b1;
        tick();
        fetch_done_in = 1'b0;
        check("f3_stray_done", 32'(fetch_rst_out), 32'd1);
        framebuffer_ready_in = 1'b1;
        tick();
        framebuffer_ready_in = 1'b0;
        check("f3_render", 32'(fetch_rst_out), 32'd0);
        pixel_valid_in = 1'b1;
        run_until(6);
        pixel_valid_in = 1'b0;
        run_until(10);
        fetch_done_in = 1'b1;
        tick();
        fetch_done_in    = 1'b0;
        pipeline_busy_in = 1'b0;
        run_until(14);
        pipeline_busy_in = 1'b1;
        tick();
        pipeline_busy_in = 1'b0;
        check("f3_restart_15", 32'(fetch_rst_out), 32'd0);
        run_until(18);
        check("f3_restart_18", 32'(fetch_rst_out), 32'd0);
        tick();
        check("f3_restart_19", 32'(fetch_rst_out), 32'd1);
        run_until(40);
        pixel_valid_in = 1'b1;
        run_until(43);
        pixel_valid_in = 1'b0;
        run_until(100);
        check("f3_clear", 32'(clear_out), 32'd1);
        tick();
        check("f3_pixels", 32'(pixel_count_out), 32'd3);
        check("f3_frames", 32'(frame_count_out), 32'd1);

        // Frame 4: overrun, fetch_done at 150.
        cyc = 0;
        pipeline_busy_in = 1'b1;
        run_until(2);
        framebuffer_ready_in = 1'b1;
        tick();
        framebuffer_ready_in = 1'b0;
        run_until(98);
        check("f4_no_overrun_yet", 32'(overrun_out), 32'd0);
        run_until(100);
        check("f4_overrun", 32'(overrun_out), 32'd1);
        run_until(150);
        fetch_done_in = 1'b1;
        tick();
        fetch_done_in    = 1'b0;
        pipeline_busy_in = 1'b0;
        run_until(154);
        check("f4_drain_154", 32'(fetch_rst_out), 32'd0);
        tick();
        check("f4_wait_timer_155", 32'(fetch_rst_out), 32'd1);
        check("f4_no_clear_155", 32'(clear_out), 32'd0);
        tick();
        check("f4_clear_156", 32'(clear_out), 32'd1);
        tick();
        check("f4_clear_single", 32'(clear_out), 32'd0);
        check("f4_frames", 32'(frame_count_out), 32'd2);
        check("f4_overrun_sticky", 32'(overrun_out), 32'd1);

        // Frame 5: 70000 pixels saturate, frame counter preloaded to wrap.
        cyc = 0;
        pipeline_busy_in = 1'b1;
        run_until(2);
        framebuffer_ready_in = 1'b1;
        tick();
        framebuffer_ready_in = 1'b0;
        pixel_valid_in = 1'b1;
        run_until(70002);
        fetch_done_in = 1'b1;
        tick();
        pixel_valid_in   = 1'b0;
        fetch_done_in    = 1'b0;
        pipeline_busy_in = 1'b0;
        tick();
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        check("f5_overrun_held", 32'(overrun_out), 32'd1);
        run_until(70008);
        check("f5_clear", 32'(clear_out), 32'd1);
        tick();
        check("f5_pixels_sat", 32'(pixel_count_out), 32'hFFFF);
        check("f5_frames_wrap", 32'(frame_count_out), 32'd0);
        check("f5_overrun", 32'(overrun_out), 32'd1);

        // Frame 6: reset asserted in the SWAP cycle.
        cyc = 0;
        pipeline_busy_in = 1'b1;
        run_until(2);
        framebuffer_ready_in = 1'b1;
        tick();
        framebuffer_ready_in = 1'b0;
        run_until(5);
        fetch_done_in = 1'b1;
        tick();
        fetch_done_in    = 1'b0;
        pipeline_busy_in = 1'b0;
        run_until(100);
        check("f6_clear", 32'(clear_out), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_reset_values("f6_swap_rst");
        tick();
        check("f6_no_pulse", 32'(clear_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
